servo_sequencer: RTL and testbench

Position controller for the servo PWM generator. Owns the 32-bit duty-cycle setpoint `dc` and arbitrates it between two sources: manual push-button nudges and an automatic waypoint sweep. The setpoint is rate-limited toward its target and only changes at PWM period boundaries, so the downstream comparator never sees a mid-period change. It sits between the debounced one-shot buttons and the PWM counter/comparator, all in the `clk_div` domain.

---
 rtl/servo_sequencer.sv | 148 ++++++++++++++
 tb/tb_servo_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sequencer.sv
// Servo duty-cycle setpoint controller: manual nudges or automatic waypoint sweep,
// with the setpoint slewed toward its target one bounded step per PWM period.
module servo_sequencer #(
    parameter logic [31:0] MIN_DC        = 32'd50_000,
    parameter logic [31:0] MAX_DC        = 32'd100_000,
    parameter logic [31:0] CENTER_DC     = 32'd75_000,
    parameter logic [31:0] STEP          = 32'd2_500,
    parameter logic [31:0] SLEW          = 32'd500,
    parameter logic [31:0] WP0           = 32'd50_000,
    parameter logic [31:0] WP1           = 32'd100_000,
    parameter logic [31:0] WP2           = 32'd75_000,
    parameter logic [31:0] WP3           = 32'd62_500,
    parameter logic [31:0] DWELL_PERIODS = 32'd10
) (
    input  logic        clk_div,
    input  logic        rst,
    input  logic        period_start,
    input  logic        inc_pulse,
    input  logic        dec_pulse,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] dc,
    output logic [31:0] target,
    output logic        busy,
    output logic        at_target,
    output logic [1:0]  wp_idx,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        AUTO_MOVE  = 2'd1,
        AUTO_DWELL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] dc_q, dc_d;
    logic [31:0] target_q, target_d;
    logic [31:0] dwell_q, dwell_d;
    logic [1:0]  wp_q, wp_d;
    logic        busy_q;
    logic        at_target_q;

    function automatic logic [31:0] clamp(input logic [31:0] v);
        if (v < MIN_DC)      return MIN_DC;
        else if (v > MAX_DC) return MAX_DC;
        else                 return v;
    endfunction

    function automatic logic [31:0] wp_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return clamp(WP0);
            2'd1:    return clamp(WP1);
            2'd2:    return clamp(WP2);
            default: return clamp(WP3);
        endcase
    endfunction

    // Differences are only formed after the comparison, so nothing wraps.
    function automatic logic [31:0] slew_step(input logic [31:0] d, input logic [31:0] t);
        if (t > d)      return ((t - d) < SLEW) ? t : d + SLEW;
        else if (t < d) return ((d - t) < SLEW) ? t : d - SLEW;
        else            return d;
    endfunction

    always_comb begin
        state_d  = state_q;
        dc_d     = dc_q;
        target_d = target_q;
        dwell_d  = dwell_q;
        wp_d     = wp_q;

        if (period_start) dc_d = slew_step(dc_q, target_q);

        case (state_q)
            MANUAL: begin
                if (start && !stop) begin
                    state_d  = AUTO_MOVE;
                    wp_d     = 2'd0;
                    target_d = wp_val(2'd0);
                end else if (inc_pulse && !dec_pulse) begin
                    target_d = (target_q >= MAX_DC - STEP) ? MAX_DC : target_q + STEP;
                end else if (dec_pulse && !inc_pulse) begin
                    target_d = (target_q <= MIN_DC + STEP) ? MIN_DC : target_q - STEP;
                end
            end
            AUTO_MOVE: begin
                if (stop) begin
                    state_d  = MANUAL;
                    target_d = dc_q;
                    dwell_d  = '0;
                end else begin
                    target_d = wp_val(wp_q);
                    if (period_start && (dc_q == target_q)) begin
                        state_d = AUTO_DWELL;
                        dwell_d = DWELL_PERIODS;
                    end
                end
            end
            AUTO_DWELL: begin
                if (stop) begin
                    state_d  = MANUAL;
                    target_d = dc_q;
                    dwell_d  = '0;
                end else if (period_start) begin
                    if (dwell_q <= 32'd1) begin
                        wp_d     = wp_q + 2'd1;
                        target_d = wp_val(wp_q + 2'd1);
                        state_d  = AUTO_MOVE;
                        dwell_d  = '0;
                    end else begin
                        dwell_d = dwell_q - 32'd1;
                    end
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q     <= MANUAL;
            dc_q        <= CENTER_DC;
            target_q    <= CENTER_DC;
            dwell_q     <= '0;
            wp_q        <= 2'd0;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            dc_q        <= dc_d;
            target_q    <= target_d;
            dwell_q     <= dwell_d;
            wp_q        <= wp_d;
            // Status flags deliberately lag the state and setpoint by one cycle.
            busy_q      <= (state_q != MANUAL);
            at_target_q <= (dc_q == target_q);
        end
    end

    assign dc        = dc_q;
    assign target    = target_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;
    assign wp_idx    = wp_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_servo_sequencer.sv
// Bench for servo_sequencer: directed pulse sequences, a per-cycle reference model
// of the setpoint rules, and literal checkpoints from hand-worked values.
module tb_servo_sequencer;

    logic        clk_div = 1'b0;
    logic        rst;
    logic        period_start, inc_pulse, dec_pulse, start, stop;
    logic [31:0] dc, target;
    logic        busy, at_target;
    logic [1:0]  wp_idx;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    servo_sequencer dut (
        .clk_div      (clk_div),
        .rst          (rst),
        .period_start (period_start),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .start        (start),
        .stop         (stop),
        .dc           (dc),
        .target       (target),
        .busy         (busy),
        .at_target    (at_target),
        .wp_idx       (wp_idx),
        .state_o      (state_o)
    );

    // clock / reset
    always #5 clk_div = ~clk_div;

    // reference model: mode 0 = manual, 1 = moving to waypoint, 2 = dwelling
    int     m_mode, p_mode;
    longint m_dc, m_tgt, p_dc, p_tgt;
    int     m_wp, m_dwell;
    bit     m_busy, m_at;
    longint wps[4] = '{50000, 100000, 75000, 62500};

    function automatic longint toward(input longint d, input longint t);
        longint gap;
        gap = (t > d) ? t - d : d - t;
        if (gap > 500) gap = 500;
        return (t > d) ? d + gap : d - gap;
    endfunction

    always @(posedge clk_div or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_dc = 75000; m_tgt = 75000; m_wp = 0; m_dwell = 0;
            m_busy = 1'b0; m_at = 1'b1;
        end else begin
            p_dc = m_dc; p_tgt = m_tgt; p_mode = m_mode;
            m_busy = (p_mode != 0);
            m_at   = (p_dc == p_tgt);
            if (period_start) m_dc = toward(p_dc, p_tgt);
            if (p_mode == 0) begin
                if (start && !stop) begin
                    m_mode = 1; m_wp = 0; m_tgt = wps[0];
                end else if (inc_pulse && !dec_pulse) begin
                    m_tgt = (p_tgt + 2500 > 100000) ? 100000 : p_tgt + 2500;
                end else if (dec_pulse && !inc_pulse) begin
                    m_tgt = (p_tgt - 2500 < 50000) ? 50000 : p_tgt - 2500;
                end
            end else if (stop) begin
                m_mode = 0; m_tgt = p_dc;
            end else if (p_mode == 1) begin
                if (period_start && p_dc == p_tgt) begin
                    m_mode = 2; m_dwell = 10;
                end
            end else if (period_start) begin
                m_dwell = m_dwell - 1;
                if (m_dwell == 0) begin
                    m_wp = (m_wp + 1) % 4; m_tgt = wps[m_wp]; m_mode = 1;
                end
            end
        end
    end

    // scoreboard helpers
    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_div);
            #1;
            if (cmp_en) begin
                chk("model_dc", dc, m_dc);
                chk("model_target", target, m_tgt);
                chk("model_busy", busy, m_busy);
                chk("model_at_target", at_target, m_at);
                chk("model_wp_idx", wp_idx, m_wp);
            end
        end
    end

    // driver tasks
    task automatic cyc(input bit ps, input bit inc, input bit dec, input bit st, input bit sp);
        @(negedge clk_div);
        period_start = ps; inc_pulse = inc; dec_pulse = dec; start = st; stop = sp;
        @(posedge clk_div);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic periods(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk_div);
        rst = 1'b1;
        @(negedge clk_div);
        rst = 1'b0;
        idle();
    endtask

    task automatic settle();
        @(negedge clk_div);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        period_start = 1'b0; inc_pulse = 1'b0; dec_pulse = 1'b0; start = 1'b0; stop = 1'b0;
        cmp_en = 1'b1;
        settle();
        chk("reset_dc", dc, 75000);
        chk("reset_target", target, 75000);
        chk("reset_busy", busy, 0);
        chk("reset_at_target", at_target, 1);
        chk("reset_wp_idx", wp_idx, 0);
        @(negedge clk_div);
        rst = 1'b0;
        idle();

        // manual nudge
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        settle();
        chk("nudge_target", target, 82500);
        periods(1);
        settle();
        chk("nudge_first_step", dc, 75500);
        periods(14);
        settle();
        chk("nudge_dc_final", dc, 82500);
        chk("nudge_at_target", at_target, 1);

        // clamps
        repeat (30) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        settle();
        chk("clamp_max", target, 100000);
        repeat (30) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        settle();
        chk("clamp_min", target, 50000);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        settle();
        chk("inc_dec_same_cycle", target, 50000);

        // sweep from reset
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        settle();
        chk("sweep_target_wp0", target, 50000);
        chk("sweep_busy", busy, 1);
        periods(50);
        settle();
        chk("sweep_reach_wp0", dc, 50000);
        chk("sweep_at_wp0", at_target, 1);
        periods(1);
        settle();
        chk("sweep_dwell_state", state_o, 2);
        periods(9);
        settle();
        chk("sweep_still_wp0", wp_idx, 0);
        periods(1);
        settle();
        chk("sweep_wp1", wp_idx, 1);
        chk("sweep_target_wp1", target, 100000);
        periods(111);
        settle();
        chk("sweep_wp2", wp_idx, 2);
        chk("sweep_target_wp2", target, 75000);
        periods(61);
        settle();
        chk("sweep_wp3", wp_idx, 3);
        chk("sweep_target_wp3", target, 62500);
        periods(36);
        settle();
        chk("sweep_wp_wrap", wp_idx, 0);
        chk("sweep_target_wrap", target, 50000);
        periods(5);
        settle();
        chk("sweep_dc_after_wrap", dc, 60000);

        // asynchronous reset mid-sweep, checked before any clock edge
        @(negedge clk_div);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dc", dc, 75000);
        chk("async_rst_target", target, 75000);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_wp_idx", wp_idx, 0);
        @(negedge clk_div);
        rst = 1'b0;
        idle();

        // stop mid-move
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        periods(30);
        settle();
        chk("stop_pre_dc", dc, 60000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        settle();
        chk("stop_target_frozen", target, 60000);
        chk("stop_busy_clear", busy, 0);
        periods(3);
        settle();
        chk("stop_dc_holds", dc, 60000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        settle();
        chk("stop_then_inc", target, 62500);

        // start + stop together in manual
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        settle();
        chk("start_stop_state", state_o, 0);
        chk("start_stop_busy", busy, 0);
        chk("start_stop_target", target, 62500);

        // period_start + inc in the same cycle uses the old target
        periods(5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        settle();
        chk("ps_inc_dc", dc, 62500);
        chk("ps_inc_target", target, 65000);
        periods(1);
        settle();
        chk("ps_inc_next_dc", dc, 63000);

        // stop + period_start: slew applies, target takes pre-slew dc
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        periods(4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        settle();
        chk("stop_ps_dc", dc, 72500);
        chk("stop_ps_target", target, 73000);
        periods(1);
        settle();
        chk("stop_ps_slew_back", dc, 73000);

        idle();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
